// File: rtl/imem_word_loader_pkg.sv
// Shared definitions for the image-memory word loader: default geometry and FSM state encoding.
package imem_word_loader_pkg;

  localparam int DEF_PIX_W        = 8;
  localparam int DEF_PIX_PER_WORD = 30;
  localparam int DEF_ADDR_W       = 8;
  localparam int DEF_DATA_W       = DEF_PIX_W * DEF_PIX_PER_WORD;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/imem_word_loader_if.sv
// Pixel stream handshake plus image-memory write port, bundled for the loader and its source/sink.
interface imem_word_loader_if
  import imem_word_loader_pkg::*;
#(
  parameter int PIX_W  = DEF_PIX_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              in_valid;
  logic [PIX_W-1:0]  in_data;
  logic              in_ready;
  logic              iMem_WEPin;
  logic [ADDR_W-1:0] iMem_WEAddress;
  logic [DATA_W-1:0] idataWrite;

  modport master (
    output in_valid, in_data,
    input  in_ready, iMem_WEPin, iMem_WEAddress, idataWrite
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, iMem_WEPin, iMem_WEAddress, idataWrite
  );

endinterface

// File: rtl/imem_word_loader_packer.sv
// Byte-lane packer: collects NPIX bytes (byte 0 in the LSB lane) and publishes the full word
// only when the last byte lands, so the write-data register never shows a partial word.
module imem_word_packer
  import imem_word_loader_pkg::*;
#(
  parameter int PW   = DEF_PIX_W,
  parameter int NPIX = DEF_PIX_PER_WORD,
  localparam int DW  = PW * NPIX,
  localparam int IW  = $clog2(NPIX)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          load_en,
  input  logic [PW-1:0] data,
  output logic          last,
  output logic [DW-1:0] word
);

  logic [IW-1:0]    idx_q;
  logic [DW-PW-1:0] lanes_q;

  assign last = (idx_q == IW'(NPIX - 1));

  // The top lane is never stored separately; it goes straight into the published word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      lanes_q <= '0;
      word    <= '0;
    end else if (clear) begin
      idx_q <= '0;
    end else if (load_en) begin
      if (last) begin
        word  <= {data, lanes_q};
        idx_q <= '0;
      end else begin
        lanes_q[idx_q*PW +: PW] <= data;
        idx_q                   <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_word_loader.sv
// Streams pixel bytes into packed memory words and writes them at consecutive addresses.
//  state | meaning
//  IDLE  | waiting for start; outputs hold
//  FILL  | accepting bytes until a word is complete
//  WRITE | single-cycle memory write of the packed word
//  DONE  | one-cycle completion pulse
module imem_word_loader
  import imem_word_loader_pkg::*;
#(
  parameter int PIX_W        = DEF_PIX_W,
  parameter int PIX_PER_WORD = DEF_PIX_PER_WORD,
  parameter int ADDR_W       = DEF_ADDR_W,
  localparam int DATA_W      = PIX_W * PIX_PER_WORD
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written,
  imem_word_loader_if.slave bus
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   target_q;
  logic [ADDR_W:0]   ww_q;
  logic [ADDR_W:0]   ww_inc;
  logic              ready;
  logic              we;
  logic              launch;
  logic              pk_clear;
  logic              accept;
  logic              last;
  logic [DATA_W-1:0] word;

  assign ww_inc = ww_q + 1'b1;
  assign accept = bus.in_valid && ready && !abort;

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    we       = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    launch   = 1'b0;
    pk_clear = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          launch   = 1'b1;
          pk_clear = 1'b1;
          state_nx = ST_FILL;
        end
      end
      ST_FILL: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (abort) state_nx = ST_IDLE;
        else if (accept && last) state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        busy = 1'b1;
        if (abort) begin
          state_nx = ST_IDLE;
        end else begin
          we       = 1'b1;
          pk_clear = 1'b1;
          state_nx = (ww_inc == target_q) ? ST_DONE : ST_FILL;
        end
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // A zero word count means a full sweep of the address space.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      target_q <= '0;
      ww_q     <= '0;
    end else begin
      state <= state_nx;
      if (launch) begin
        addr_q   <= base_addr;
        target_q <= (num_words == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, num_words};
        ww_q     <= '0;
      end else if (we) begin
        addr_q <= addr_q + 1'b1;
        ww_q   <= ww_inc;
      end
    end
  end

  imem_word_packer #(
    .PW   (PIX_W),
    .NPIX (PIX_PER_WORD)
  ) u_packer (
    .clock   (clock),
    .reset   (reset),
    .clear   (pk_clear),
    .load_en (accept),
    .data    (bus.in_data),
    .last    (last),
    .word    (word)
  );

  assign bus.in_ready       = ready;
  assign bus.iMem_WEPin     = we;
  assign bus.iMem_WEAddress = addr_q;
  assign bus.idataWrite     = word;
  assign words_written      = ww_q;

endmodule

// File: tb/tb_imem_word_loader.sv
// Bench for imem_word_loader: table of load scenarios with random stalls/data, checked against
// a byte-list model of which words must land at which addresses.
module tb_imem_word_loader;
  import imem_word_loader_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] base_addr = 8'h00;
  logic [7:0] num_words = 8'h00;
  logic       busy, done;
  logic [8:0] words_written;

  imem_word_loader_if #(.PIX_W(8), .ADDR_W(8), .DATA_W(240)) bus ();

  imem_word_loader dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .num_words     (num_words),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .words_written (words_written),
    .bus           (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]   addr;
    logic [239:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] base;
    logic [7:0] num;
    int         stall;
    int         abort_byte;
    int         abort_word;
    int         restart_byte;
    bit         seq;
    int         exp_ww;
    int         exp_done;
  } vec_t;

  wr_t  wr_q[$];
  wr_t  exp_q[$];
  vec_t vecs[9];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [239:0] act, input logic [239:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (bus.iMem_WEPin === 1'b1) begin
      wr_q.push_back('{bus.iMem_WEAddress, bus.idataWrite});
      chk("ready_low_in_write", 240'(bus.in_ready), 240'(0));
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic run_vec(input vec_t v, input int vi);
    int           nw, total, accepted, cyc, w;
    bit           finished, abort_now, hs;
    logic [239:0] cur, seqw;
    nw       = (v.num == 8'd0) ? 256 : int'(v.num);
    total    = nw * 30;
    accepted = 0;
    cyc      = 0;
    finished = 1'b0;
    cur      = '0;
    wr_q.delete();
    exp_q.delete();
    done_cnt = 0;

    tick();
    start = 1'b1; base_addr = v.base; num_words = v.num;
    tick();
    start = 1'b0; base_addr = 8'($urandom); num_words = 8'($urandom);

    while (!finished) begin
      if (cyc > total * 5 + 200) begin
        chk("timeout", 240'(1), 240'(0));
        break;
      end
      abort_now    = (accepted == v.abort_byte);
      abort        = abort_now;
      start        = (accepted == v.restart_byte);
      base_addr    = 8'h77;
      bus.in_valid = (int'($urandom_range(99)) >= v.stall);
      bus.in_data  = v.seq ? 8'(accepted) : 8'($urandom);
      @(negedge clock);
      hs = bus.in_valid && bus.in_ready;
      tick();
      cyc++;
      if (abort_now) begin
        abort = 1'b0;
        finished = 1'b1;
        @(negedge clock);
        chk("abort_to_idle_busy", 240'(busy), 240'(0));
        tick();
      end else if (hs) begin
        cur[(accepted % 30) * 8 +: 8] = bus.in_data;
        accepted++;
        if (accepted % 30 == 0) begin
          w            = accepted / 30 - 1;
          bus.in_valid = 1'b0;
          start        = 1'b0;
          abort        = (w == v.abort_word);
          @(negedge clock);
          chk("we_after_last_byte", 240'(bus.iMem_WEPin), 240'(!abort));
          chk("ready_in_write", 240'(bus.in_ready), 240'(0));
          if (!abort) exp_q.push_back('{8'(int'(v.base) + w), cur});
          tick();
          if (abort) begin
            abort = 1'b0;
            finished = 1'b1;
          end else if (accepted == total) begin
            @(negedge clock);
            chk("done_pulse", 240'(done), 240'(1));
            chk("busy_in_done", 240'(busy), 240'(0));
            tick();
            finished = 1'b1;
          end
        end
      end
    end

    start = 1'b0; abort = 1'b0; bus.in_valid = 1'b0;
    repeat (3) tick();
    chk($sformatf("v%0d_done_count", vi), 240'(done_cnt), 240'(v.exp_done));
    chk($sformatf("v%0d_words_written", vi), 240'(words_written), 240'(v.exp_ww));
    chk($sformatf("v%0d_busy_after", vi), 240'(busy), 240'(0));
    chk($sformatf("v%0d_write_count", vi), 240'(wr_q.size()), 240'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      chk($sformatf("v%0d_addr%0d", vi, i), 240'(wr_q[i].addr), 240'(exp_q[i].addr));
      chk($sformatf("v%0d_data%0d", vi, i), wr_q[i].data, exp_q[i].data);
    end
    if (v.seq && wr_q.size() > 0) begin
      for (int k = 0; k < 30; k++) seqw[k*8 +: 8] = 8'(k);
      chk("seq_word_layout", wr_q[0].data, seqw);
    end
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    vecs[0] = '{8'h10, 8'd1, 0,  -1, -1, -1, 1'b1, 1,   1};
    vecs[1] = '{8'h00, 8'd3, 40, -1, -1, -1, 1'b0, 3,   1};
    vecs[2] = '{8'hFE, 8'd3, 20, -1, -1, -1, 1'b0, 3,   1};
    vecs[3] = '{8'h00, 8'd0, 0,  -1, -1, -1, 1'b0, 256, 1};
    vecs[4] = '{8'h40, 8'd4, 30, 45, -1, -1, 1'b0, 1,   0};
    vecs[5] = '{8'h50, 8'd2, 0,  -1, 1,  -1, 1'b0, 1,   0};
    vecs[6] = '{8'h30, 8'd2, 25, -1, -1, -1, 1'b0, 2,   1};
    vecs[7] = '{8'h20, 8'd1, 10, -1, -1, 5,  1'b0, 1,   1};
    vecs[8] = '{8'h80, 8'd5, 50, -1, -1, -1, 1'b0, 5,   1};

    #2;
    chk("rst_in_ready", 240'(bus.in_ready), 240'(0));
    chk("rst_we", 240'(bus.iMem_WEPin), 240'(0));
    chk("rst_busy", 240'(busy), 240'(0));
    chk("rst_done", 240'(done), 240'(0));
    chk("rst_addr", 240'(bus.iMem_WEAddress), 240'(0));
    chk("rst_data", bus.idataWrite, 240'(0));
    chk("rst_ww", 240'(words_written), 240'(0));
    #10 reset = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // abort and start together in IDLE: abort wins
    n = wr_q.size();
    tick();
    start = 1'b1; abort = 1'b1; base_addr = 8'h99; num_words = 8'd1;
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge clock);
    chk("abort_start_busy", 240'(busy), 240'(0));
    chk("abort_start_ready", 240'(bus.in_ready), 240'(0));
    tick();

    // asynchronous reset in the middle of a fill
    start = 1'b1; base_addr = 8'h33; num_words = 8'd2;
    tick();
    start = 1'b0; bus.in_valid = 1'b1;
    repeat (10) begin
      bus.in_data = 8'($urandom);
      tick();
    end
    chk("fill_busy_before_reset", 240'(busy), 240'(1));
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", 240'(busy), 240'(0));
    chk("mid_rst_ready", 240'(bus.in_ready), 240'(0));
    chk("mid_rst_addr", 240'(bus.iMem_WEAddress), 240'(0));
    chk("mid_rst_data", bus.idataWrite, 240'(0));
    chk("mid_rst_ww", 240'(words_written), 240'(0));
    @(negedge clock);
    reset = 1'b0;
    n = wr_q.size();
    repeat (40) begin
      bus.in_data = 8'($urandom);
      tick();
    end
    chk("no_write_after_reset", 240'(wr_q.size()), 240'(n));
    chk("idle_after_reset_ready", 240'(bus.in_ready), 240'(0));
    bus.in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
